// File: rtl/brisc_pkg.sv
// brisc shared package: ISA constants, line geometry
// and fetch-stage state encoding.
package brisc_pkg;

   localparam int ILEN             = 32;
   localparam int CACHE_LINE_LEN   = 512;
   localparam int LINE_WORDS       = CACHE_LINE_LEN / ILEN;
   localparam int LINE_OFFSET_BITS = 6;
   localparam int TAG_BITS         = 32 - LINE_OFFSET_BITS;

   localparam logic [31:0] PC_BOOT   = 32'h0000_1000;
   localparam logic [31:0] PC_EXCEPT = 32'h0000_2000;
   localparam logic [31:0] NOP       = 32'h0000_0013;

   typedef enum logic [1:0] {
      FETCH_RUN,
      FETCH_REQ,
      FETCH_WAIT
   } fetch_state_e;

endpackage

// File: rtl/brisc_line_buffer.sv
// Single-line instruction buffer: tag, data, valid,
// with a fill port and a combinational hit/word port.
module brisc_line_buffer
   import brisc_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      fill_i,
   input  logic [TAG_BITS-1:0]       fill_tag_i,
   input  logic [CACHE_LINE_LEN-1:0] fill_data_i,
   input  logic [31:0]               pc_i,
   output logic                      hit_o,
   output logic [ILEN-1:0]           word_o
);

   logic                      valid_q;
   logic [TAG_BITS-1:0]       tag_q;
   logic [CACHE_LINE_LEN-1:0] data_q;

   // Capture a whole refilled line in one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         tag_q   <= '0;
         data_q  <= '0;
      end else if (fill_i) begin
         valid_q <= 1'b1;
         tag_q   <= fill_tag_i;
         data_q  <= fill_data_i;
      end
   end

   assign hit_o  = valid_q &&
                   (tag_q == pc_i[31:LINE_OFFSET_BITS]);
   assign word_o = data_q[{pc_i[5:2], 5'b0} +: ILEN];

endmodule

// File: rtl/brisc_fetch_stage.sv
// Instruction fetch: PC, refill FSM, discard flag and
// the IF/ID register feeding decode.
module brisc_fetch_stage
   import brisc_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         redirect_valid_i,
   input  logic [31:0]  redirect_pc_i,
   input  logic         except_i,
   output logic         mem_req_valid_o,
   output logic [31:0]  mem_req_addr_o,
   input  logic         mem_req_ready_i,
   input  logic         mem_resp_valid_i,
   input  logic [511:0] mem_resp_data_i,
   output logic         if_valid_o,
   output logic [31:0]  if_instr_o,
   output logic [31:0]  if_pc_o,
   input  logic         if_ready_i
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic         discard_q, discard_d;
   logic         req_valid_q, req_valid_d;
   logic [31:0]  req_addr_q, req_addr_d;
   logic         ifv_q, ifv_d;
   logic [31:0]  ifi_q, ifi_d;
   logic [31:0]  ifpc_q, ifpc_d;

   logic         hit;
   logic [31:0]  word;
   logic         fill;
   logic         redir;
   logic [31:0]  target;
   logic         adv;

   brisc_line_buffer u_line (
      .clk         (clk),
      .rst_n       (rst_n),
      .fill_i      (fill),
      .fill_tag_i  (req_addr_q[31:LINE_OFFSET_BITS]),
      .fill_data_i (mem_resp_data_i),
      .pc_i        (pc_q),
      .hit_o       (hit),
      .word_o      (word)
   );

   assign redir  = except_i | redirect_valid_i;
   assign target = except_i ? PC_EXCEPT
                            : {redirect_pc_i[31:2], 2'b00};
   assign adv    = (state_q == FETCH_RUN) && hit &&
                   (!ifv_q || if_ready_i);

   // PC and IF/ID update: redirect beats advance beats drain.
   always_comb begin
      pc_d   = pc_q;
      ifv_d  = ifv_q;
      ifi_d  = ifi_q;
      ifpc_d = ifpc_q;
      if (redir) begin
         pc_d  = target;
         ifv_d = 1'b0;
         ifi_d = NOP;
      end else if (adv) begin
         pc_d   = pc_q + 32'd4;
         ifv_d  = 1'b1;
         ifi_d  = word;
         ifpc_d = pc_q;
      end else if (ifv_q && if_ready_i) begin
         ifv_d = 1'b0;
         ifi_d = NOP;
      end
   end

   // Refill FSM; request stays stable until accepted.
   always_comb begin
      state_d     = state_q;
      discard_d   = discard_q;
      req_valid_d = req_valid_q;
      req_addr_d  = req_addr_q;
      fill        = 1'b0;
      unique case (state_q)
         FETCH_RUN: begin
            if (!redir && !hit) begin
               state_d     = FETCH_REQ;
               req_valid_d = 1'b1;
               req_addr_d  = {pc_q[31:LINE_OFFSET_BITS],
                              {LINE_OFFSET_BITS{1'b0}}};
            end
         end
         FETCH_REQ: begin
            if (redir) discard_d = 1'b1;
            if (mem_req_ready_i) begin
               state_d     = FETCH_WAIT;
               req_valid_d = 1'b0;
            end
         end
         FETCH_WAIT: begin
            if (redir) discard_d = 1'b1;
            if (mem_resp_valid_i) begin
               fill      = !discard_q && !redir;
               discard_d = 1'b0;
               state_d   = FETCH_RUN;
            end
         end
         default: state_d = FETCH_RUN;
      endcase
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= FETCH_RUN;
         pc_q        <= PC_BOOT;
         discard_q   <= 1'b0;
         req_valid_q <= 1'b0;
         req_addr_q  <= '0;
         ifv_q       <= 1'b0;
         ifi_q       <= NOP;
         ifpc_q      <= PC_BOOT;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         discard_q   <= discard_d;
         req_valid_q <= req_valid_d;
         req_addr_q  <= req_addr_d;
         ifv_q       <= ifv_d;
         ifi_q       <= ifi_d;
         ifpc_q      <= ifpc_d;
      end
   end

   assign mem_req_valid_o = req_valid_q;
   assign mem_req_addr_o  = req_addr_q;
   assign if_valid_o      = ifv_q;
   assign if_instr_o      = ifi_q;
   assign if_pc_o         = ifpc_q;

endmodule

// File: tb/tb_brisc_fetch_stage.sv
// Bench for brisc_fetch_stage: memory responder,
// expected-stream scoreboard and directed/random stimulus.
module tb_brisc_fetch_stage;
   import brisc_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         redirect_valid_i = 1'b0;
   logic [31:0]  redirect_pc_i = '0;
   logic         except_i = 1'b0;
   logic         mem_req_valid_o;
   logic [31:0]  mem_req_addr_o;
   logic         mem_req_ready_i = 1'b0;
   logic         mem_resp_valid_i = 1'b0;
   logic [511:0] mem_resp_data_i = '0;
   logic         if_valid_o;
   logic [31:0]  if_instr_o;
   logic [31:0]  if_pc_o;
   logic         if_ready_i = 1'b1;

   always #5 clk = ~clk;

   brisc_fetch_stage dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .redirect_valid_i (redirect_valid_i),
      .redirect_pc_i    (redirect_pc_i),
      .except_i         (except_i),
      .mem_req_valid_o  (mem_req_valid_o),
      .mem_req_addr_o   (mem_req_addr_o),
      .mem_req_ready_i  (mem_req_ready_i),
      .mem_resp_valid_i (mem_resp_valid_i),
      .mem_resp_data_i  (mem_resp_data_i),
      .if_valid_o       (if_valid_o),
      .if_instr_o       (if_instr_o),
      .if_pc_o          (if_pc_o),
      .if_ready_i       (if_ready_i)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h",
                  name, act, exp);
      end
   endtask

   // Memory contents: boot line holds 0x100+i.
   function automatic logic [31:0] mword(input logic [31:0] a);
      logic [31:0] boot;
      boot = PC_BOOT;
      if (a[31:6] == boot[31:6])
         return 32'h100 + {28'd0, a[5:2]};
      return a ^ 32'hC0DE_0000;
   endfunction

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
   } exp_t;

   exp_t        expq[$];
   logic [31:0] next_pc;

   function automatic void fill_q();
      while (expq.size() < 16) begin
         exp_t e;
         e.pc  = next_pc;
         e.ins = mword(next_pc);
         expq.push_back(e);
         next_pc = next_pc + 32'd4;
      end
   endfunction

   function automatic void restart(input logic [31:0] t);
      expq.delete();
      next_pc = t;
      fill_q();
   endfunction

   // Memory responder.
   int          mode = 1;
   int          lat = 3;
   int          pend = 0;
   logic [31:0] paddr = '0;
   logic [31:0] req_log[$];

   initial forever begin
      @(negedge clk);
      mem_resp_valid_i = 1'b0;
      if (!rst_n) begin
         pend = 0;
      end else if (pend > 0) begin
         pend--;
         if (pend == 0) begin
            mem_resp_valid_i = 1'b1;
            for (int i = 0; i < 16; i++)
               mem_resp_data_i[32*i +: 32] =
                  mword({paddr[31:6], i[3:0], 2'b00});
         end
      end
      if (mode == 0)      mem_req_ready_i = 1'b0;
      else if (mode == 1) mem_req_ready_i = 1'b1;
      else mem_req_ready_i = ($urandom_range(0, 3) != 0);
      #4;
      if (rst_n && mem_req_valid_o && mem_req_ready_i) begin
         req_log.push_back(mem_req_addr_o);
         paddr = mem_req_addr_o;
         pend  = lat;
      end
   end

   // Scoreboard monitor: sampled just before each rising edge.
   initial forever begin
      @(negedge clk);
      #4;
      if (rst_n) begin
         if (if_valid_o) begin
            if (expq.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL sb_underflow: got pc %h expected none",
                        if_pc_o);
            end else begin
               check("if_pc", if_pc_o, expq[0].pc);
               check("if_instr", if_instr_o, expq[0].ins);
               if (if_ready_i) begin
                  void'(expq.pop_front());
                  fill_q();
               end
            end
         end else begin
            check("nop_when_invalid", if_instr_o, NOP);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_req(input int n, input int lim);
      int k = 0;
      while (req_log.size() < n && k < lim) begin
         @(negedge clk);
         k++;
      end
      check("req_timeout", (req_log.size() >= n), 1);
   endtask

   task automatic req_at(input string name, input int idx,
                         input logic [31:0] exp);
      if (req_log.size() > idx)
         check(name, req_log[idx], exp);
      else
         check(name, 32'hFFFF_FFFF, exp);
   endtask

   // Called at a falling edge; returns at the next one.
   task automatic do_redir(input logic [31:0] t,
                           input logic ex, input logic rv);
      redirect_valid_i = rv;
      except_i         = ex;
      redirect_pc_i    = {t[31:2], 2'(($urandom_range(0, 3)))};
      @(posedge clk);
      #1;
      restart(ex ? PC_EXCEPT : {t[31:2], 2'b00});
      @(negedge clk);
      redirect_valid_i = 1'b0;
      except_i         = 1'b0;
   endtask

   task automatic check_reset();
      check("rst_req_valid", mem_req_valid_o, 0);
      check("rst_req_addr", mem_req_addr_o, 0);
      check("rst_if_valid", if_valid_o, 0);
      check("rst_if_instr", if_instr_o, NOP);
      check("rst_if_pc", if_pc_o, PC_BOOT);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int n;
      int k;
      logic [31:0] t;
      restart(PC_BOOT);
      cyc(2);
      check_reset();
      rst_n = 1'b1;

      // Boot: first request at the boot line.
      wait_req(1, 50);
      req_at("boot_req", 0, PC_BOOT);
      lat = 6;

      // Redirect hit while streaming at 0x1008.
      k = 0;
      while (!(if_valid_o && if_pc_o == 32'h1008) && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("reach_1008", if_pc_o, 32'h1008);
      n = req_log.size();
      do_redir(32'h1020, 1'b0, 1'b1);
      check("redir_valid0", if_valid_o, 0);
      check("redir_nop", if_instr_o, NOP);
      @(negedge clk);
      check("redir_valid1", if_valid_o, 1);
      check("redir_pc", if_pc_o, 32'h1020);
      check("redir_no_req", req_log.size(), n);

      // Decode stall mid-line.
      if_ready_i = 1'b0;
      cyc(4);
      if_ready_i = 1'b1;

      // Second line request, then redirect while waiting.
      wait_req(2, 200);
      req_at("line2_req", 1, 32'h1040);
      do_redir(32'h3000, 1'b0, 1'b1);
      wait_req(3, 100);
      req_at("redir_refill_req", 2, 32'h3000);

      // Exception wins over a simultaneous redirect.
      cyc(10);
      do_redir(32'h1000, 1'b1, 1'b1);
      check("exc_valid0", if_valid_o, 0);
      wait_req(4, 100);
      req_at("exc_req", 3, PC_EXCEPT);

      // Request back-pressure.
      cyc(10);
      mode = 0;
      do_redir(32'h5000, 1'b0, 1'b1);
      k = 0;
      while (!mem_req_valid_o && k < 20) begin
         @(negedge clk);
         k++;
      end
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", mem_req_valid_o, 1);
         check("bp_addr", mem_req_addr_o, 32'h5000);
         @(negedge clk);
      end
      n = req_log.size();
      mode = 1;
      wait_req(n + 1, 50);
      req_at("bp_req", n, 32'h5000);

      // Asynchronous reset during a refill.
      cyc(15);
      lat = 8;
      n = req_log.size();
      do_redir(32'h6000, 1'b0, 1'b1);
      wait_req(n + 1, 50);
      req_at("pre_rst_req", n, 32'h6000);
      cyc(2);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset();
      cyc(3);
      restart(PC_BOOT);
      lat = 3;
      n = req_log.size();
      rst_n = 1'b1;
      wait_req(n + 1, 50);
      req_at("post_rst_req", n, PC_BOOT);

      // Randomized traffic.
      mode = 2;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         lat = $urandom_range(1, 5);
         if_ready_i = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 19) == 0) begin
            case ($urandom_range(0, 3))
               0: t = 32'h1000;
               1: t = 32'h3000;
               2: t = 32'h4000;
               default: t = PC_EXCEPT;
            endcase
            t = t + 32'($urandom_range(0, 31)) * 4;
            do_redir(t, ($urandom_range(0, 7) == 0), 1'b1);
         end
      end
      if_ready_i = 1'b1;
      cyc(20);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
